aes_sbox_arbiter: RTL and testbench

- Time-multiplexed S-box resource shared between two requesters:
  - the cipher round datapath, which needs full 128-bit SubBytes or InvSubBytes;
  - the key-expansion unit, which needs 32-bit SubWord.
- Replaces 16 parallel S-boxes plus 4 key-schedule S-boxes with one bank of LANES forward and LANES inverse S-box lanes.
- Sequences multi-beat state substitution and arbitrates access between the two requesters.
- Sits between the round controller / key expander and the aes_sbox / aes_inv_sbox primitives.

---
 rtl/aes_sbox_arbiter_if.sv | 31 +++
 rtl/aes_sbox_arbiter.sv | 178 +++++++++++++++++
 tb/tb_aes_sbox_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_sbox_arbiter_if.sv
// Handshake bundle between the shared S-box arbiter and its two requesters
// (state substitution from the round datapath, SubWord from key expansion).
interface aes_sbox_arbiter_if;
  logic         st_req_valid;
  logic         st_req_ready;
  logic [127:0] st_req_data;
  logic         st_req_inv;
  logic         st_rsp_valid;
  logic         st_rsp_ready;
  logic [127:0] st_rsp_data;
  logic         kw_req_valid;
  logic         kw_req_ready;
  logic [31:0]  kw_req_data;
  logic         kw_rsp_valid;
  logic         kw_rsp_ready;
  logic [31:0]  kw_rsp_data;

  modport master (
    output st_req_valid, st_req_data, st_req_inv, st_rsp_ready,
    output kw_req_valid, kw_req_data, kw_rsp_ready,
    input  st_req_ready, st_rsp_valid, st_rsp_data,
    input  kw_req_ready, kw_rsp_valid, kw_rsp_data
  );

  modport slave (
    input  st_req_valid, st_req_data, st_req_inv, st_rsp_ready,
    input  kw_req_valid, kw_req_data, kw_rsp_ready,
    output st_req_ready, st_rsp_valid, st_rsp_data,
    output kw_req_ready, kw_rsp_valid, kw_rsp_data
  );
endinterface

// File: rtl/aes_sbox_arbiter.sv
// One bank of LANES forward + LANES inverse S-boxes, time-shared between a
// multi-beat 128-bit state substitution and a single-beat 32-bit SubWord.
module aes_sbox_arbiter #(
  parameter int LANES        = 4,
  parameter bit KEY_PRIORITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  aes_sbox_arbiter_if.slave bus,
  output logic              busy
);
  localparam int BEATS = 16 / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LW    = 8 * LANES;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, ST_RUN, KW_RUN, ST_RSP, KW_RSP} state_e;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    return gf_mul(gf_mul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  state_e         state_q, state_d;
  logic [CW-1:0]  beat_q, beat_d;
  logic           rr_q, rr_d;
  logic [127:0]   st_in_q, st_in_d;
  logic           inv_q, inv_d;
  logic [31:0]    kw_in_q, kw_in_d;
  logic [127:0]   st_out_q, st_out_d;
  logic [31:0]    kw_out_q, kw_out_d;
  logic           st_vld_q, st_vld_d;
  logic           kw_vld_q, kw_vld_d;

  logic           kw_ready, st_ready, kw_acc, st_acc;
  int             beat_base;
  logic [LW-1:0]  lane_in, fwd_out, inv_out;

  // rr_q == 0 means the key requester is favoured on the next contention.
  assign kw_ready = (state_q == IDLE) && (KEY_PRIORITY || !bus.st_req_valid || !rr_q);
  assign st_ready = (state_q == IDLE) && !(bus.kw_req_valid && kw_ready);
  assign kw_acc   = kw_ready && bus.kw_req_valid;
  assign st_acc   = st_ready && bus.st_req_valid;

  assign bus.kw_req_ready = kw_ready;
  assign bus.st_req_ready = st_ready;
  assign bus.st_rsp_valid = st_vld_q;
  assign bus.st_rsp_data  = st_out_q;
  assign bus.kw_rsp_valid = kw_vld_q;
  assign bus.kw_rsp_data  = kw_out_q;
  assign busy             = (state_q != IDLE);

  // A SubWord beat borrows lanes 0..3; beat_q is zero whenever KW_RUN is active.
  always_comb begin
    beat_base = int'(beat_q) * LW;
    lane_in   = st_in_q[beat_base +: LW];
    if (state_q == KW_RUN) lane_in[31:0] = kw_in_q;
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign fwd_out[8*gi +: 8] = sbox_fwd(lane_in[8*gi +: 8]);
    assign inv_out[8*gi +: 8] = sbox_inv(lane_in[8*gi +: 8]);
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    rr_d     = rr_q;
    st_in_d  = st_in_q;
    inv_d    = inv_q;
    kw_in_d  = kw_in_q;
    st_out_d = st_out_q;
    kw_out_d = kw_out_q;
    st_vld_d = st_vld_q;
    kw_vld_d = kw_vld_q;
    unique case (state_q)
      IDLE: begin
        if (kw_acc) begin
          kw_in_d = bus.kw_req_data;
          state_d = KW_RUN;
          if (bus.st_req_valid) rr_d = 1'b1;
        end else if (st_acc) begin
          st_in_d = bus.st_req_data;
          inv_d   = bus.st_req_inv;
          beat_d  = '0;
          state_d = ST_RUN;
          if (bus.kw_req_valid) rr_d = 1'b0;
        end
      end
      ST_RUN: begin
        st_out_d[beat_base +: LW] = inv_q ? inv_out : fwd_out;
        if (beat_q == LAST_BEAT) begin
          beat_d   = '0;
          st_vld_d = 1'b1;
          state_d  = ST_RSP;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      KW_RUN: begin
        kw_out_d = fwd_out[31:0];
        kw_vld_d = 1'b1;
        state_d  = KW_RSP;
      end
      ST_RSP: begin
        if (bus.st_rsp_ready) begin
          st_vld_d = 1'b0;
          state_d  = IDLE;
        end
      end
      KW_RSP: begin
        if (bus.kw_rsp_ready) begin
          kw_vld_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      rr_q     <= 1'b0;
      st_in_q  <= '0;
      inv_q    <= 1'b0;
      kw_in_q  <= '0;
      st_out_q <= '0;
      kw_out_q <= '0;
      st_vld_q <= 1'b0;
      kw_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      rr_q     <= rr_d;
      st_in_q  <= st_in_d;
      inv_q    <= inv_d;
      kw_in_q  <= kw_in_d;
      st_out_q <= st_out_d;
      kw_out_q <= kw_out_d;
      st_vld_q <= st_vld_d;
      kw_vld_q <= kw_vld_d;
    end
  end
endmodule

// File: tb/tb_aes_sbox_arbiter.sv
// Drives four arbiter configurations (LANES 4/8/16, plus key-priority) with the
// same stimulus and checks each against a latency/queue model every cycle.
module tb_aes_sbox_arbiter;
  localparam int NDUT = 4;
  localparam logic [127:0] FWD_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FWD_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

  function automatic int cfg_lanes(input int i);
    return (i == 1) ? 8 : (i == 2) ? 16 : 4;
  endfunction
  function automatic bit cfg_kp(input int i);
    return (i == 3);
  endfunction

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         st_req_valid = 1'b0, st_req_inv = 1'b0, st_rsp_ready = 1'b0;
  logic         kw_req_valid = 1'b0, kw_rsp_ready = 1'b0;
  logic [127:0] st_req_data = '0;
  logic [31:0]  kw_req_data = '0;

  logic [NDUT-1:0] st_rdy_w, kw_rdy_w, st_vld_w, kw_vld_w, busy_w;
  logic [127:0]    st_dat_w [NDUT];
  logic [31:0]     kw_dat_w [NDUT];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    aes_sbox_arbiter_if bus ();
    assign bus.st_req_valid = st_req_valid;
    assign bus.st_req_data  = st_req_data;
    assign bus.st_req_inv   = st_req_inv;
    assign bus.st_rsp_ready = st_rsp_ready;
    assign bus.kw_req_valid = kw_req_valid;
    assign bus.kw_req_data  = kw_req_data;
    assign bus.kw_rsp_ready = kw_rsp_ready;
    aes_sbox_arbiter #(.LANES(cfg_lanes(gi)), .KEY_PRIORITY(cfg_kp(gi))) dut (
      .clk(clk), .rst(rst), .bus(bus.slave), .busy(busy_w[gi])
    );
    assign st_rdy_w[gi] = bus.st_req_ready;
    assign kw_rdy_w[gi] = bus.kw_req_ready;
    assign st_vld_w[gi] = bus.st_rsp_valid;
    assign kw_vld_w[gi] = bus.kw_rsp_valid;
    assign st_dat_w[gi] = bus.st_rsp_data;
    assign kw_dat_w[gi] = bus.kw_rsp_data;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string nm, input int j, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @cyc %0d: got %h, expected %h", nm, j, cyc, act, exp);
    end
  endtask

  // S-box tables generated by walking the multiplicative group with generator 3.
  logic [7:0] sb [256];
  logic [7:0] isb [256];

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
  endtask

  function automatic logic [127:0] sub_bytes(input logic [127:0] d, input bit inv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv ? isb[d[8*i +: 8]] : sb[d[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sb[w[8*i +: 8]];
    return r;
  endfunction

  // Model per DUT: 0 = free, 1 = state txn, 2 = key txn; a countdown of busy
  // cycles before the response appears, and a favoured-requester flag.
  int           m_pend [NDUT];
  int           m_wait [NDUT];
  bit           m_rr   [NDUT];
  bit           m_stv  [NDUT];
  bit           m_kwv  [NDUT];
  logic [127:0] m_std  [NDUT];
  logic [127:0] m_stres[NDUT];
  logic [31:0]  m_kwd  [NDUT];
  logic [31:0]  m_kwres[NDUT];

  function automatic bit m_key_pref(input int j);
    return cfg_kp(j) || !st_req_valid || !m_rr[j];
  endfunction

  initial begin
    for (int j = 0; j < NDUT; j++) begin
      m_pend[j] = 0; m_wait[j] = 0; m_rr[j] = 0; m_stv[j] = 0; m_kwv[j] = 0;
      m_std[j] = '0; m_stres[j] = '0; m_kwd[j] = '0; m_kwres[j] = '0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int j = 0; j < NDUT; j++) begin
        if (rst) begin
          m_pend[j] = 0; m_wait[j] = 0; m_rr[j] = 0;
          m_stv[j] = 0; m_kwv[j] = 0; m_std[j] = '0; m_kwd[j] = '0;
        end else if (m_pend[j] == 0) begin
          if (kw_req_valid && m_key_pref(j)) begin
            m_pend[j] = 2; m_wait[j] = 1; m_kwres[j] = sub_word(kw_req_data);
            if (st_req_valid) m_rr[j] = 1;
          end else if (st_req_valid) begin
            m_pend[j] = 1; m_wait[j] = 16 / cfg_lanes(j);
            m_stres[j] = sub_bytes(st_req_data, st_req_inv);
            if (kw_req_valid) m_rr[j] = 0;
          end
        end else if (m_wait[j] > 0) begin
          m_wait[j]--;
          if (m_wait[j] == 0) begin
            if (m_pend[j] == 1) begin m_stv[j] = 1; m_std[j] = m_stres[j]; end
            else begin m_kwv[j] = 1; m_kwd[j] = m_kwres[j]; end
          end
        end else if (m_pend[j] == 1) begin
          if (st_rsp_ready) begin m_stv[j] = 0; m_pend[j] = 0; end
        end else if (kw_rsp_ready) begin
          m_kwv[j] = 0; m_pend[j] = 0;
        end
      end
    end
  end

  // Compare process: every observable output of every DUT, every cycle.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int j = 0; j < NDUT; j++) begin
        bit kr;
        kr = (m_pend[j] == 0) && m_key_pref(j);
        check("kw_req_ready", j, kw_rdy_w[j], kr);
        check("st_req_ready", j, st_rdy_w[j], (m_pend[j] == 0) && !(kw_req_valid && kr));
        check("busy", j, busy_w[j], m_pend[j] != 0);
        check("st_rsp_valid", j, st_vld_w[j], m_stv[j]);
        check("kw_rsp_valid", j, kw_vld_w[j], m_kwv[j]);
        if (m_stv[j]) check("st_rsp_data", j, st_dat_w[j], m_std[j]);
        if (m_kwv[j]) check("kw_rsp_data", j, kw_dat_w[j], m_kwd[j]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input bit key, output int c);
    c = -1;
    for (int k = 0; k < 30 && c < 0; k++) begin
      @(negedge clk);
      if (key ? (kw_rdy_w[0] && kw_req_valid) : (st_rdy_w[0] && st_req_valid)) c = cyc;
    end
    check(key ? "kw_grant_seen" : "st_grant_seen", 0, c >= 0, 1);
  endtask

  task automatic run_state(input logic [127:0] d, input bit inv, input logic [127:0] exp);
    int c;
    int lat [NDUT];
    int nbusy, nvld;
    st_req_data = d; st_req_inv = inv; st_rsp_ready = 1'b1; st_req_valid = 1'b1;
    wait_grant(1'b0, c);
    step();
    st_req_valid = 1'b0;
    for (int j = 0; j < NDUT; j++) lat[j] = -1;
    nbusy = 0; nvld = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      nbusy += int'(busy_w[0]);
      nvld  += int'(st_vld_w[0]);
      for (int j = 0; j < NDUT; j++) begin
        if (lat[j] < 0 && st_vld_w[j]) begin
          lat[j] = cyc - c;
          check("st_result_literal", j, st_dat_w[j], exp);
        end
      end
    end
    for (int j = 0; j < NDUT; j++) check("st_latency", j, lat[j], 16 / cfg_lanes(j) + 1);
    check("st_busy_cycles", 0, nbusy, 5);
    check("st_valid_cycles", 0, nvld, 1);
    $display("state txn inv=%0d in=%h out=%h latency=%0d", inv, d, st_dat_w[0], lat[0]);
    step();
  endtask

  task automatic run_key(input logic [31:0] d, input logic [31:0] exp);
    int c;
    int lat [NDUT];
    int nbusy;
    kw_req_data = d; kw_rsp_ready = 1'b1; kw_req_valid = 1'b1;
    wait_grant(1'b1, c);
    step();
    kw_req_valid = 1'b0;
    for (int j = 0; j < NDUT; j++) lat[j] = -1;
    nbusy = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      nbusy += int'(busy_w[0]);
      for (int j = 0; j < NDUT; j++) begin
        if (lat[j] < 0 && kw_vld_w[j]) begin
          lat[j] = cyc - c;
          check("kw_result_literal", j, kw_dat_w[j], exp);
        end
      end
    end
    for (int j = 0; j < NDUT; j++) check("kw_latency", j, lat[j], 2);
    check("kw_busy_cycles", 0, nbusy, 2);
    $display("key txn in=%h out=%h latency=%0d", d, kw_dat_w[0], lat[0]);
    step();
  endtask

  initial begin
    int c;
    int g0[$];
    int g3[$];
    build_tables();
    check("model_sbox_00", 0, sb[8'h00], 8'h63);
    check("model_sbox_53", 0, sb[8'h53], 8'hed);
    check("model_sbox_ff", 0, sb[8'hff], 8'h16);
    check("model_isbox_00", 0, isb[8'h00], 8'h52);

    // Reset state
    step();
    chk_en = 1'b1;
    step();
    @(negedge clk);
    check("rst_st_rsp_valid", 0, st_vld_w[0], 0);
    check("rst_kw_rsp_valid", 0, kw_vld_w[0], 0);
    check("rst_busy", 0, busy_w[0], 0);
    check("rst_st_rsp_data", 0, st_dat_w[0], 0);
    check("rst_kw_rsp_data", 0, kw_dat_w[0], 0);
    check("rst_kw_req_ready", 0, kw_rdy_w[0], 1);
    step();
    rst = 1'b0;
    step();

    run_state(FWD_IN, 1'b0, FWD_OUT);
    run_state(FWD_OUT, 1'b1, FWD_IN);
    run_state({16{8'h63}}, 1'b1, 128'h0);
    run_key(32'hcf4f3c09, 32'h8a84eb01);
    run_key(32'h00000000, 32'h63636363);

    // Contention from reset: both requesters hold valid continuously.
    rst = 1'b1;
    st_req_data = FWD_IN; st_req_inv = 1'b0; kw_req_data = 32'hcf4f3c09;
    st_req_valid = 1'b1; kw_req_valid = 1'b1; st_rsp_ready = 1'b1; kw_rsp_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (kw_req_valid && kw_rdy_w[0]) g0.push_back(1);
      else if (st_req_valid && st_rdy_w[0]) g0.push_back(2);
      if (kw_req_valid && kw_rdy_w[3]) g3.push_back(1);
      else if (st_req_valid && st_rdy_w[3]) g3.push_back(2);
    end
    step();
    st_req_valid = 1'b0; kw_req_valid = 1'b0;
    check("rr_grant_count", 0, g0.size() >= 4, 1);
    check("prio_grant_count", 3, g3.size() >= 4, 1);
    if (g0.size() >= 4) for (int k = 0; k < 4; k++) check("rr_grant_order", 0, g0[k], (k % 2 == 0) ? 1 : 2);
    if (g3.size() >= 4) for (int k = 0; k < 4; k++) check("prio_grant_order", 3, g3[k], 1);
    $display("contention txn rr_grants=%0d prio_grants=%0d", g0.size(), g3.size());
    repeat (12) step();

    // Backpressure: response held, key request waits, resumes after handshake.
    st_rsp_ready = 1'b0;
    st_req_data = FWD_IN; st_req_inv = 1'b0; st_req_valid = 1'b1;
    wait_grant(1'b0, c);
    step();
    st_req_valid = 1'b0; kw_req_data = 32'h00000000; kw_req_valid = 1'b1; kw_rsp_ready = 1'b1;
    c = -1;
    for (int k = 0; k < 10 && c < 0; k++) begin
      @(negedge clk);
      if (st_vld_w[0]) c = cyc;
    end
    check("bp_valid_seen", 0, c >= 0, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_valid_hold", 0, st_vld_w[0], 1);
      check("bp_data_hold", 0, st_dat_w[0], FWD_OUT);
      check("bp_kw_ready_low", 0, kw_rdy_w[0], 0);
      check("bp_st_ready_low", 0, st_rdy_w[0], 0);
    end
    step();
    st_rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_handshake_valid", 0, st_vld_w[0], 1);
    check("bp_handshake_kw_ready", 0, kw_rdy_w[0], 0);
    step();
    @(negedge clk);
    check("bp_resume_kw_ready", 0, kw_rdy_w[0], 1);
    step();
    kw_req_valid = 1'b0;
    $display("backpressure txn out=%h", st_dat_w[0]);
    repeat (12) step();

    // Reset in the middle of a state operation (beat 2).
    st_req_data = FWD_OUT; st_req_inv = 1'b1; st_req_valid = 1'b1; st_rsp_ready = 1'b1;
    wait_grant(1'b0, c);
    step();
    st_req_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("midrst_no_rsp", 0, st_vld_w[0], 0);
      check("midrst_idle", 0, busy_w[0], 0);
    end
    $display("mid-op reset txn discarded");
    step();
    run_state(FWD_IN, 1'b0, FWD_OUT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
